// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the dynamic branch predictor:
// table geometry defaults, 2-bit counter encodings and the zero word.
package branch_predictor_pkg;

   localparam int BP_ENTRIES = 64;
   localparam int BP_INDEX_W = 6;
   localparam int BP_TAG_W   = 8;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt_e;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/branch_predictor_table.sv
// Predictor storage: one asynchronous read port for IF, one for the ID update path,
// and a single synchronous write port. Reset clears valid bits and counters only.
module bp_table
   import branch_predictor_pkg::*;
#(
   parameter int   ENTRIES  = BP_ENTRIES,
   parameter int   INDEX_W  = BP_INDEX_W,
   parameter int   TAG_W    = BP_TAG_W,
   parameter cnt_e INIT_CNT = WNT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] i_rd_idx,
   output logic               o_rd_valid,
   output logic [TAG_W-1:0]   o_rd_tag,
   output logic [31:0]        o_rd_target,
   output cnt_e               o_rd_cnt,
   input  logic [INDEX_W-1:0] i_up_idx,
   output logic               o_up_valid,
   output logic [TAG_W-1:0]   o_up_tag,
   output logic [31:0]        o_up_target,
   output cnt_e               o_up_cnt,
   input  logic               i_wr_en,
   input  logic [INDEX_W-1:0] i_wr_idx,
   input  logic [TAG_W-1:0]   i_wr_tag,
   input  logic [31:0]        i_wr_target,
   input  cnt_e               i_wr_cnt
);

   logic               r_valid  [ENTRIES];
   cnt_e               r_cnt    [ENTRIES];
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [31:0]        r_target [ENTRIES];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i] <= 1'b0;
            r_cnt[i]   <= INIT_CNT;
         end
      end else if (i_wr_en) begin
         r_valid[i_wr_idx] <= 1'b1;
         r_cnt[i_wr_idx]   <= i_wr_cnt;
      end
   end

   // Tag and target need no reset: they are ignored while valid is clear.
   always_ff @(posedge clk) begin
      if (rst && i_wr_en) begin
         r_tag[i_wr_idx]    <= i_wr_tag;
         r_target[i_wr_idx] <= i_wr_target;
      end
   end

   assign o_rd_valid  = r_valid[i_rd_idx];
   assign o_rd_tag    = r_tag[i_rd_idx];
   assign o_rd_target = r_target[i_rd_idx];
   assign o_rd_cnt    = r_cnt[i_rd_idx];

   assign o_up_valid  = r_valid[i_up_idx];
   assign o_up_tag    = r_tag[i_up_idx];
   assign o_up_target = r_target[i_up_idx];
   assign o_up_cnt    = r_cnt[i_up_idx];

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit branch predictor with BTB tags: predicts in IF, carries the
// prediction to ID, flags mispredicts and trains the table from the resolved outcome.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int         ENTRIES  = BP_ENTRIES,
   parameter int         INDEX_W  = BP_INDEX_W,
   parameter int         TAG_W    = BP_TAG_W,
   parameter logic [1:0] INIT_CNT = 2'b01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc_i,
   input  logic        if_valid_i,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic        pred_taken_o,
   output logic [31:0] pred_target_o,
   input  logic        id_branch_i,
   input  logic        id_taken_i,
   input  logic [31:0] id_target_i,
   output logic        mispredict_o,
   output logic [31:0] redirect_pc_o
);

   function automatic cnt_e sat_inc(input cnt_e c);
      case (c)
         SNT:     return WNT;
         WNT:     return WT;
         default: return ST;
      endcase
   endfunction

   function automatic cnt_e sat_dec(input cnt_e c);
      case (c)
         ST:      return WT;
         WT:      return WNT;
         default: return SNT;
      endcase
   endfunction

   logic                r_id_vld;
   logic [31:0]         r_pc;
   logic                r_pred_taken;
   logic [31:0]         r_pred_target;

   logic [INDEX_W-1:0]  w_if_idx;
   logic [TAG_W-1:0]    w_if_tag;
   logic [INDEX_W-1:0]  w_id_idx;
   logic [TAG_W-1:0]    w_id_tag;
   logic                w_rd_valid;
   logic [TAG_W-1:0]    w_rd_tag;
   logic [31:0]         w_rd_target;
   cnt_e                w_rd_cnt;
   logic                w_up_valid;
   logic [TAG_W-1:0]    w_up_tag;
   logic [31:0]         w_up_target;
   cnt_e                w_up_cnt;
   logic                w_if_hit;
   logic                w_up_hit;
   logic                w_resolve;
   logic                w_update;
   logic                w_wr_en;
   logic [31:0]         w_wr_target;
   cnt_e                w_wr_cnt;
   logic [31-INDEX_W-TAG_W:0] w_unused_pc_bits;

   assign w_if_idx = if_pc_i[INDEX_W+1:2];
   assign w_if_tag = if_pc_i[INDEX_W+TAG_W+1:INDEX_W+2];
   assign w_id_idx = r_pc[INDEX_W+1:2];
   assign w_id_tag = r_pc[INDEX_W+TAG_W+1:INDEX_W+2];
   assign w_unused_pc_bits = {if_pc_i[31:INDEX_W+TAG_W+2], if_pc_i[1:0]};

   bp_table #(
      .ENTRIES  (ENTRIES),
      .INDEX_W  (INDEX_W),
      .TAG_W    (TAG_W),
      .INIT_CNT (cnt_e'(INIT_CNT))
   ) u_table (
      .clk         (clk),
      .rst         (rst),
      .i_rd_idx    (w_if_idx),
      .o_rd_valid  (w_rd_valid),
      .o_rd_tag    (w_rd_tag),
      .o_rd_target (w_rd_target),
      .o_rd_cnt    (w_rd_cnt),
      .i_up_idx    (w_id_idx),
      .o_up_valid  (w_up_valid),
      .o_up_tag    (w_up_tag),
      .o_up_target (w_up_target),
      .o_up_cnt    (w_up_cnt),
      .i_wr_en     (w_wr_en),
      .i_wr_idx    (w_id_idx),
      .i_wr_tag    (w_id_tag),
      .i_wr_target (w_wr_target),
      .i_wr_cnt    (w_wr_cnt)
   );

   assign w_if_hit      = w_rd_valid && (w_rd_tag == w_if_tag);
   assign pred_taken_o  = w_if_hit && ((w_rd_cnt == WT) || (w_rd_cnt == ST));
   assign pred_target_o = pred_taken_o ? w_rd_target : ZERO_WORD;

   // Flush wins over stall so a squashed instruction never resolves.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_id_vld      <= 1'b0;
         r_pc          <= ZERO_WORD;
         r_pred_taken  <= 1'b0;
         r_pred_target <= ZERO_WORD;
      end else if (flush_i) begin
         r_id_vld      <= 1'b0;
      end else if (!stall_i) begin
         r_id_vld      <= if_valid_i;
         r_pc          <= if_pc_i;
         r_pred_taken  <= pred_taken_o;
         r_pred_target <= pred_target_o;
      end
   end

   assign w_resolve     = r_id_vld && id_branch_i;
   assign mispredict_o  = w_resolve && ((r_pred_taken != id_taken_i) ||
                          (id_taken_i && (r_pred_target != id_target_i)));
   // Not-taken falls through past the delay slot, hence pc+8.
   assign redirect_pc_o = mispredict_o ? (id_taken_i ? id_target_i : r_pc + 32'd8)
                                       : ZERO_WORD;

   assign w_update = w_resolve && !stall_i && !flush_i;
   assign w_up_hit = w_up_valid && (w_up_tag == w_id_tag);

   always_comb begin
      w_wr_en     = 1'b0;
      w_wr_target = w_up_target;
      w_wr_cnt    = w_up_cnt;
      if (w_update) begin
         if (w_up_hit) begin
            w_wr_en  = 1'b1;
            w_wr_cnt = id_taken_i ? sat_inc(w_up_cnt) : sat_dec(w_up_cnt);
            if (id_taken_i) begin
               w_wr_target = id_target_i;
            end
         end else if (id_taken_i) begin
            w_wr_en     = 1'b1;
            w_wr_cnt    = WT;
            w_wr_target = id_target_i;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: cold allocate, counter training and saturation,
// stall hold, aliasing, flush and reset-during-stall, with hand-computed expectations.
module tb_branch_predictor;

   localparam logic [31:0] PC_A    = 32'h0040_0010;
   localparam logic [31:0] PC_B    = 32'h0040_1010;
   localparam logic [31:0] PC_C    = 32'h0040_0200;
   localparam logic [31:0] PC_IDLE = 32'h0040_0100;
   localparam logic [31:0] T1      = 32'h0040_0040;
   localparam logic [31:0] T2      = 32'h0040_0080;
   localparam logic [31:0] TB      = 32'h0040_1040;
   localparam logic [31:0] DS_A    = 32'h0040_0018;
   localparam logic [31:0] DS_B    = 32'h0040_1018;

   logic        clk;
   logic        rst;
   logic [31:0] if_pc_i;
   logic        if_valid_i;
   logic        stall_i;
   logic        flush_i;
   logic        pred_taken_o;
   logic [31:0] pred_target_o;
   logic        id_branch_i;
   logic        id_taken_i;
   logic [31:0] id_target_i;
   logic        mispredict_o;
   logic [31:0] redirect_pc_o;

   int n_vec;
   int n_err;

   branch_predictor dut (
      .clk           (clk),
      .rst           (rst),
      .if_pc_i       (if_pc_i),
      .if_valid_i    (if_valid_i),
      .stall_i       (stall_i),
      .flush_i       (flush_i),
      .pred_taken_o  (pred_taken_o),
      .pred_target_o (pred_target_o),
      .id_branch_i   (id_branch_i),
      .id_taken_i    (id_taken_i),
      .id_target_i   (id_target_i),
      .mispredict_o  (mispredict_o),
      .redirect_pc_o (redirect_pc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] pc);
      if_pc_i     = pc;
      if_valid_i  = 1'b1;
      id_branch_i = 1'b0;
      tick();
   endtask

   task automatic predict(input string tag, input logic [31:0] pc,
                          input logic exp_t, input logic [31:0] exp_tgt);
      if_pc_i     = pc;
      id_branch_i = 1'b0;
      #1;
      check({tag, "_taken"}, 32'(pred_taken_o), 32'(exp_t));
      check({tag, "_target"}, pred_target_o, exp_tgt);
   endtask

   // Fetch pc, then resolve it in ID while an unrelated PC is fetched.
   task automatic resolve(input string tag, input logic [31:0] pc, input logic taken,
                          input logic [31:0] tgt, input logic exp_mis,
                          input logic [31:0] exp_redir);
      fetch(pc);
      if_pc_i     = PC_IDLE;
      id_branch_i = 1'b1;
      id_taken_i  = taken;
      id_target_i = tgt;
      #1;
      check({tag, "_mis"}, 32'(mispredict_o), 32'(exp_mis));
      check({tag, "_redir"}, redirect_pc_o, exp_redir);
      tick();
      id_branch_i = 1'b0;
   endtask

   initial begin
      n_vec       = 0;
      n_err       = 0;
      rst         = 1'b0;
      if_pc_i     = PC_A;
      if_valid_i  = 1'b1;
      stall_i     = 1'b0;
      flush_i     = 1'b0;
      id_branch_i = 1'b1;
      id_taken_i  = 1'b1;
      id_target_i = T1;

      // Reset state, with a resolving branch presented to prove vld gating
      tick();
      tick();
      check("rst_pred_taken", 32'(pred_taken_o), 32'd0);
      check("rst_pred_target", pred_target_o, 32'd0);
      check("rst_mis", 32'(mispredict_o), 32'd0);
      check("rst_redir", redirect_pc_o, 32'd0);
      rst         = 1'b1;
      id_branch_i = 1'b0;
      #1;
      check("post_rst_pred", 32'(pred_taken_o), 32'd0);

      // Cold taken branch allocates with cnt=10
      resolve("cold", PC_A, 1'b1, T1, 1'b1, T1);
      predict("cold_after", PC_A, 1'b1, T1);

      // Not-taken training 10->01->00->00, then taken back up with saturation
      resolve("nt1", PC_A, 1'b0, 32'd0, 1'b1, DS_A);
      predict("nt1_after", PC_A, 1'b0, 32'd0);
      resolve("nt2", PC_A, 1'b0, 32'd0, 1'b0, 32'd0);
      resolve("nt3", PC_A, 1'b0, 32'd0, 1'b0, 32'd0);
      resolve("t1", PC_A, 1'b1, T1, 1'b1, T1);
      predict("t1_after", PC_A, 1'b0, 32'd0);
      resolve("t2", PC_A, 1'b1, T1, 1'b1, T1);
      predict("t2_after", PC_A, 1'b1, T1);
      resolve("t3", PC_A, 1'b1, T1, 1'b0, 32'd0);
      resolve("t4", PC_A, 1'b1, T1, 1'b0, 32'd0);
      resolve("nt_sat", PC_A, 1'b0, 32'd0, 1'b1, DS_A);
      predict("nt_sat_after", PC_A, 1'b1, T1);
      resolve("tgt_chg", PC_A, 1'b1, T2, 1'b1, T2);
      predict("tgt_chg_after", PC_A, 1'b1, T2);

      // Stall with a resolving branch in ID: hold for 3 edges, one update after release
      fetch(PC_A);
      if_pc_i     = PC_IDLE;
      stall_i     = 1'b1;
      id_branch_i = 1'b1;
      id_taken_i  = 1'b0;
      #1;
      check("stall_mis0", 32'(mispredict_o), 32'd1);
      check("stall_redir0", redirect_pc_o, DS_A);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_mis", 32'(mispredict_o), 32'd1);
         check("stall_redir", redirect_pc_o, DS_A);
         if_pc_i = PC_A;
         #1;
         check("stall_table", 32'(pred_taken_o), 32'd1);
         if_pc_i = PC_IDLE;
      end
      stall_i = 1'b0;
      tick();
      id_branch_i = 1'b0;
      predict("stall_rel", PC_A, 1'b1, T2);
      resolve("stall_chk", PC_A, 1'b0, 32'd0, 1'b1, DS_A);
      predict("stall_chk_after", PC_A, 1'b0, 32'd0);

      // Aliasing: same index, different tag replaces the entry
      resolve("alias", PC_B, 1'b1, TB, 1'b1, TB);
      predict("alias_b", PC_B, 1'b1, TB);
      predict("alias_a", PC_A, 1'b0, 32'd0);

      // Miss, not taken: no allocation
      resolve("miss_nt", PC_C, 1'b0, 32'd0, 1'b0, 32'd0);
      predict("miss_nt_after", PC_C, 1'b0, 32'd0);

      // Flush (together with stall) while a branch resolves: no update, vld cleared
      fetch(PC_B);
      if_pc_i     = PC_IDLE;
      stall_i     = 1'b1;
      flush_i     = 1'b1;
      id_branch_i = 1'b1;
      id_taken_i  = 1'b0;
      #1;
      check("flush_mis0", 32'(mispredict_o), 32'd1);
      check("flush_redir0", redirect_pc_o, DS_B);
      tick();
      check("flush_mis1", 32'(mispredict_o), 32'd0);
      check("flush_redir1", redirect_pc_o, 32'd0);
      flush_i = 1'b0;
      stall_i = 1'b0;
      predict("flush_after", PC_B, 1'b1, TB);

      // Read during write: IF sees the pre-write entry
      fetch(PC_A);
      if_pc_i     = PC_A;
      id_branch_i = 1'b1;
      id_taken_i  = 1'b1;
      id_target_i = T1;
      #1;
      check("rdw_mis0", 32'(mispredict_o), 32'd1);
      tick();
      check("rdw_mis1", 32'(mispredict_o), 32'd1);
      id_branch_i = 1'b0;
      if_pc_i     = PC_IDLE;
      tick();
      predict("rdw_after", PC_A, 1'b1, T1);

      // Reset in the middle of a stalled resolve clears the table and ID register
      fetch(PC_B);
      if_pc_i     = PC_IDLE;
      stall_i     = 1'b1;
      id_branch_i = 1'b1;
      id_taken_i  = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check("rst_stall_mis", 32'(mispredict_o), 32'd0);
      check("rst_stall_redir", redirect_pc_o, 32'd0);
      stall_i = 1'b0;
      predict("rst_stall_b", PC_B, 1'b0, 32'd0);
      predict("rst_stall_a", PC_A, 1'b0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
